// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES reseed scheduler: FSM state encoding and
// the default encryption budget between two reseeds.
package aes_sched_pkg;

  typedef enum logic [1:0] {
    NOSEED = 2'd0,
    IDLE   = 2'd1,
    ENC    = 2'd2,
    RESEED = 2'd3
  } sched_state_t;

  localparam int MAX_ENC_DEFAULT = 1024;

endpackage

// File: rtl/aes_sched_cnt.sv
// Encryption counter: synchronous clear takes priority over increment,
// asynchronous active-low reset.
module aes_sched_cnt #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc)
      count <= count + CW'(1);
  end

endmodule

// File: rtl/aes_reseed_scheduler.sv
// Gates user traffic into the AES core so that at most MAX_ENC encryptions
// run per seed; reseeds on budget exhaustion or software request.
module aes_reseed_scheduler
  import aes_sched_pkg::*;
#(
  parameter int MAX_ENC = MAX_ENC_DEFAULT,
  parameter int CW      = $clog2(MAX_ENC + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          usr_in_valid,
  output logic          usr_in_ready,
  output logic          usr_out_valid,
  input  logic          usr_out_ready,
  input  logic          ent_seed_valid,
  output logic          ent_seed_ready,
  output logic          core_in_valid,
  input  logic          core_in_ready,
  input  logic          core_out_valid,
  output logic          core_out_ready,
  output logic          core_seed_valid,
  input  logic          core_seed_ready,
  input  logic          reseed_req,
  output logic          need_seed,
  output logic [CW-1:0] enc_count
);

  sched_state_t state, state_nxt;
  logic         pending;
  logic         seed_done;
  logic         enc_start;
  logic         at_limit;

  assign at_limit = (enc_count == CW'(MAX_ENC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= NOSEED;
    else
      state <= state_nxt;
  end

  // A request coinciding with a seed handshake is satisfied by that seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pending <= 1'b0;
    else if (seed_done)
      pending <= 1'b0;
    else if (reseed_req)
      pending <= 1'b1;
  end

  always_comb begin
    state_nxt       = state;
    usr_in_ready    = 1'b0;
    usr_out_valid   = 1'b0;
    ent_seed_ready  = 1'b0;
    core_in_valid   = 1'b0;
    core_out_ready  = 1'b0;
    core_seed_valid = 1'b0;
    need_seed       = 1'b0;
    seed_done       = 1'b0;
    enc_start       = 1'b0;
    case (state)
      NOSEED, RESEED: begin
        need_seed       = 1'b1;
        core_seed_valid = ent_seed_valid;
        ent_seed_ready  = core_seed_ready;
        if (ent_seed_valid && core_seed_ready) begin
          seed_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        // Reseed wins over any user input offered in the same cycle.
        if (at_limit || pending) begin
          state_nxt = RESEED;
        end else begin
          core_in_valid = usr_in_valid;
          usr_in_ready  = core_in_ready;
          if (usr_in_valid && core_in_ready) begin
            enc_start = 1'b1;
            state_nxt = ENC;
          end
        end
      end
      ENC: begin
        usr_out_valid  = core_out_valid;
        core_out_ready = usr_out_ready;
        if (core_out_valid && usr_out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = NOSEED;
    endcase
  end

  aes_sched_cnt #(
    .CW(CW)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (seed_done),
    .inc  (enc_start),
    .count(enc_count)
  );

endmodule

// File: tb/tb_aes_reseed_scheduler.sv
// Randomized bench for aes_reseed_scheduler against a behavioural model of
// the seed/encryption budget rules, plus a few directed sequences.
module tb_aes_reseed_scheduler;

  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk;
  logic          rst_n;
  logic          usr_in_valid, usr_in_ready;
  logic          usr_out_valid, usr_out_ready;
  logic          ent_seed_valid, ent_seed_ready;
  logic          core_in_valid, core_in_ready;
  logic          core_out_valid, core_out_ready;
  logic          core_seed_valid, core_seed_ready;
  logic          reseed_req;
  logic          need_seed;
  logic [CW-1:0] enc_count;

  int pass_count = 0;
  int total_count = 0;

  // Model: waiting for a seed, one encryption in flight, budget used, request latched.
  bit m_waiting;
  bit m_in_flight;
  int m_count;
  bit m_pending;

  aes_reseed_scheduler #(
    .MAX_ENC(MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .usr_in_valid   (usr_in_valid),
    .usr_in_ready   (usr_in_ready),
    .usr_out_valid  (usr_out_valid),
    .usr_out_ready  (usr_out_ready),
    .ent_seed_valid (ent_seed_valid),
    .ent_seed_ready (ent_seed_ready),
    .core_in_valid  (core_in_valid),
    .core_in_ready  (core_in_ready),
    .core_out_valid (core_out_valid),
    .core_out_ready (core_out_ready),
    .core_seed_valid(core_seed_valid),
    .core_seed_ready(core_seed_ready),
    .reseed_req     (reseed_req),
    .need_seed      (need_seed),
    .enc_count      (enc_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count++;
    if (obs === exp)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic modelReset();
    m_waiting   = 1'b1;
    m_in_flight = 1'b0;
    m_count     = 0;
    m_pending   = 1'b0;
  endtask

  task automatic checkAll();
    bit blocked;
    bit e_uir, e_uov, e_esr, e_civ, e_cor, e_csv, e_ns;
    blocked = (m_count == MAX) || m_pending;
    e_uir = 0; e_uov = 0; e_esr = 0; e_civ = 0; e_cor = 0; e_csv = 0; e_ns = 0;
    if (m_waiting) begin
      e_ns  = 1;
      e_csv = ent_seed_valid;
      e_esr = core_seed_ready;
    end else if (m_in_flight) begin
      e_uov = core_out_valid;
      e_cor = usr_out_ready;
    end else if (!blocked) begin
      e_civ = usr_in_valid;
      e_uir = core_in_ready;
    end
    checkOutput("need_seed", 32'(need_seed), 32'(e_ns));
    checkOutput("usr_in_ready", 32'(usr_in_ready), 32'(e_uir));
    checkOutput("usr_out_valid", 32'(usr_out_valid), 32'(e_uov));
    checkOutput("ent_seed_ready", 32'(ent_seed_ready), 32'(e_esr));
    checkOutput("core_in_valid", 32'(core_in_valid), 32'(e_civ));
    checkOutput("core_out_ready", 32'(core_out_ready), 32'(e_cor));
    checkOutput("core_seed_valid", 32'(core_seed_valid), 32'(e_csv));
    checkOutput("enc_count", 32'(enc_count), 32'(m_count));
  endtask

  // Advance the model across one rising edge using the inputs held this cycle.
  task automatic modelStep();
    if (m_waiting) begin
      if (ent_seed_valid && core_seed_ready) begin
        m_waiting = 0;
        m_count   = 0;
        m_pending = 0;
        return;
      end
    end else if (m_in_flight) begin
      if (core_out_valid && usr_out_ready) m_in_flight = 0;
    end else if ((m_count == MAX) || m_pending) begin
      m_waiting = 1;
    end else if (usr_in_valid && core_in_ready) begin
      m_in_flight = 1;
      m_count++;
    end
    if (reseed_req) m_pending = 1;
  endtask

  // Called just after a falling edge: drive, check, cross the rising edge.
  task automatic applyStimulus(input bit uiv, input bit cir, input bit cov, input bit uor,
                               input bit esv, input bit csr, input bit rr);
    usr_in_valid    = uiv;
    core_in_ready   = cir;
    core_out_valid  = cov;
    usr_out_ready   = uor;
    ent_seed_valid  = esv;
    core_seed_ready = csr;
    reseed_req      = rr;
    #1;
    checkAll();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    usr_in_valid = 0; core_in_ready = 0; core_out_valid = 0; usr_out_ready = 0;
    ent_seed_valid = 1; core_seed_ready = 1; reseed_req = 0;
    modelReset();
    #3;
    checkAll();
    ent_seed_valid = 0;
    #1;
    checkAll();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Seed offered continuously, core accepts on the fourth cycle only.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    // Exhaust the budget, see the next request blocked, reseed, then accept it.
    for (int i = 0; i < MAX; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 1, 1, 1, 0, 0);
    end
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("count_after_reseed", 32'(enc_count), 32'd1);

    // Request during ENC: ciphertext completes first, then a reseed.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    // Request coinciding with the seed handshake is absorbed by it.
    applyStimulus(1, 1, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of an encryption with ciphertext on offer.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    usr_in_valid = 0; core_out_valid = 1; usr_out_ready = 0;
    #1;
    checkAll();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_usr_out_valid", 32'(usr_out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0,
                    ($urandom % 3) != 0, ($urandom % 2) != 0, ($urandom % 4) == 0,
                    ($urandom % 20) == 0);
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/aes_reseed_scheduler.md
AES_RESEED_SCHEDULER -- requirements
Module: aes_reseed_scheduler

Interface
REQ-001 SHALL have parameter MAX_ENC, default 1024: encryptions allowed between two reseeds; legal range 1..65535.
REQ-002 SHALL have parameter CW, default $clog2(MAX_ENC+1): width of enc_count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port usr_in_valid / usr_in_ready, input / output, 1 bit each: user plaintext+key stream handshake.
REQ-006 SHALL have port usr_out_valid / usr_out_ready, output / input, 1 bit each: user ciphertext stream handshake.
REQ-007 SHALL have port ent_seed_valid / ent_seed_ready, input / output, 1 bit each: entropy-source 80-bit seed handshake (seed data wired around this block).
REQ-008 SHALL have port core_in_valid / core_in_ready, output / input, 1 bit each: AES top input handshake.
REQ-009 SHALL have port core_out_valid / core_out_ready, input / output, 1 bit each: AES top output handshake.
REQ-010 SHALL have port core_seed_valid / core_seed_ready, output / input, 1 bit each: AES top seed handshake; core_seed_ready is a one-cycle accept pulse.
REQ-011 SHALL have port reseed_req, input, 1 bit: single-cycle software request for a reseed.
REQ-012 SHALL have port need_seed, output, 1 bit: high while the block waits for a seed.
REQ-013 SHALL have port enc_count, output, CW bits: number of encryptions accepted since the last reseed.

Function
REQ-014 SHALL implement FSM states NOSEED, IDLE, ENC and RESEED; the reset state is NOSEED.
REQ-015 SHALL, in NOSEED and RESEED, drive core_seed_valid=ent_seed_valid, ent_seed_ready=core_seed_ready, core_in_valid=0, usr_in_ready=0 and need_seed=1.
REQ-016 SHALL, in NOSEED or RESEED, move to IDLE on the cycle after ent_seed_valid and core_seed_ready are both high, and at that edge clear enc_count to 0 and clear pending.
REQ-017 SHALL, in IDLE with enc_count==MAX_ENC or pending=1, move to RESEED with usr_in_ready=0 and core_in_valid=0 in that cycle; reseed has priority over user input.
REQ-018 SHALL, in IDLE otherwise, drive core_in_valid=usr_in_valid and usr_in_ready=core_in_ready, and on handshake move to ENC and increment enc_count by 1.
REQ-019 SHALL, in ENC, drive usr_out_valid=core_out_valid and core_out_ready=usr_out_ready, hold core_in_valid=0, and move to IDLE on the output handshake.
REQ-020 SHALL drive usr_out_valid=0 and core_out_ready=0 outside ENC, and core_seed_valid=0 and ent_seed_ready=0 outside NOSEED and RESEED.
REQ-021 SHALL add zero cycles of latency: all handshake outputs are combinational from state plus the partner input.
REQ-022 SHALL set a pending flag on reseed_req in any state; a reseed_req in the same cycle as a seed handshake SHALL be consumed by that reseed (pending cleared).
REQ-023 SHALL never let enc_count exceed MAX_ENC, because IDLE blocks at MAX_ENC; enc_count SHALL never wrap.
REQ-024 SHALL ignore an ent_seed_valid that arrives in IDLE or ENC, with ent_seed_ready=0 there; no seed is forwarded mid-encryption.
REQ-025 SHALL NOT reset the internal state on core_out_valid in IDLE (spurious); that event is ignored.

Reset
REQ-026 SHALL, on rst_n low, immediately force state=NOSEED, enc_count=0 and pending=0, regardless of any in-flight encryption or seed.
REQ-027 SHALL produce the following output values during reset: need_seed=1, usr_in_ready=0, usr_out_valid=0, core_in_valid=0, core_out_ready=0, core_seed_valid=ent_seed_valid, ent_seed_ready=core_seed_ready.
REQ-028 SHALL release reset synchronously via an external synchronizer; no behaviour is defined for rst_n deassertion close to a clk edge.

Structure
REQ-029 SHALL place the state encoding (2-bit enumeration) and the MAX_ENC default constant in package aes_sched_pkg.
REQ-030 SHALL contain one sub-module, aes_sched_cnt: a CW-bit counter with synchronous clear, increment and async reset.
REQ-031 SHALL hold all registers as state, enc_count and pending; no datapath registers.

Verification
REQ-032 Reset, then ent_seed_valid=1 with core_seed_ready pulsed at cycle 3 -> ent_seed_ready high at cycle 3 only, state IDLE at cycle 4, need_seed=0, enc_count=0.
REQ-033 With MAX_ENC=4, run 4 back-to-back encryptions -> enc_count=4, 5th usr_in_valid sees usr_in_ready=0 and need_seed=1; after the seed handshake, the 5th encryption is accepted and enc_count=1.
REQ-034 Pulse reseed_req while in ENC -> the ciphertext still completes, then RESEED is entered, with core_in_valid held 0 until the seed handshake.
REQ-035 Pulse reseed_req in the same cycle as a RESEED seed handshake -> return to IDLE with pending=0, with no second reseed.
REQ-036 Drop rst_n mid-ENC with core_out_valid=1 -> usr_out_valid=0 immediately, state NOSEED, enc_count=0.
REQ-037 Drive ent_seed_valid=1 during IDLE and ENC -> ent_seed_ready=0 and core_seed_valid=0 in every such cycle.
